fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: synchronous-RAM fetch feeding a 2-entry decode FIFO.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / redir_cnt performance counters.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; no requests issued
// S_RUN  | fetching; FIFO and in-flight tag active
// S_HALT | stop instruction consumed; only reset leaves this state
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    input  logic               redir_valid,
    input  logic [31:0]        redir_pc,
    input  logic               halt,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        redir_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;

    logic [31:0] q_pc   [2];
    logic [31:0] q_inst [2];
    logic [1:0]  fifo_count;

    logic        if_valid;
    logic        if_kill;
    logic [31:0] if_pc;

    logic        run;
    logic        flush;
    logic        pop;
    logic        push;
    logic        wr_slot;
    logic [2:0]  occ;

    always_comb begin
        run     = (state == S_RUN);
        flush   = run & (redir_valid | halt);
        // A handshake in a redirect cycle is void: the entry belongs to the old stream.
        pop     = dec_valid & dec_ready & ~redir_valid;
        push    = if_valid & ~if_kill & ~flush;
        occ     = {1'b0, fifo_count} + {2'b00, if_valid} - {2'b00, pop};
        wr_slot = ((fifo_count - {1'b0, pop}) != 2'd0);
        imem_en = run & ~redir_valid & ~halt & (occ < 3'd2);
    end

    assign imem_addr = fetch_pc[IMEM_AW+1:2];
    assign dec_valid = (fifo_count != 2'd0);
    assign pc        = q_pc[0];
    assign inst      = q_inst[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            halted     <= 1'b0;
            fetch_pc   <= RESET_PC;
            fifo_count <= 2'd0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_inst[0]  <= '0;
            q_inst[1]  <= '0;
            if_valid   <= 1'b0;
            if_kill    <= 1'b0;
            if_pc      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt && !redir_valid) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    halted <= 1'b0;
                end
            endcase

            if (run) begin
                if (redir_valid) begin
                    fetch_pc <= redir_pc;
                end else if (imem_en) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end

            // Tag describes the read data that returns in the following cycle.
            if_valid <= imem_en;
            if_kill  <= flush;
            if (imem_en) begin
                if_pc <= fetch_pc;
            end

            if (flush) begin
                fifo_count <= 2'd0;
            end else begin
                if (pop) begin
                    q_pc[0]   <= q_pc[1];
                    q_inst[0] <= q_inst[1];
                end
                if (push) begin
                    if (wr_slot) begin
                        q_pc[1]   <= if_pc;
                        q_inst[1] <= imem_rdata;
                    end else begin
                        q_pc[0]   <= if_pc;
                        q_inst[0] <= imem_rdata;
                    end
                end
                fifo_count <= fifo_count - {1'b0, pop} + {1'b0, push};
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (pop) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (run && redir_valid) begin
                redir_cnt <= redir_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory model returns word n = n one cycle after imem_en.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        halt;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redir_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem_en ? {18'd0, imem_addr} : 32'hDEAD_BEEF;
    end

    fetch_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .pc          (pc),
        .inst        (inst),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halt        (halt),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .redir_cnt   (redir_cnt)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        start       = 1'b0;
        dec_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'd0;
        halt        = 1'b0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
    endtask

    // Pulse start for one IDLE cycle; returns 1ns into the first RUN cycle.
    task automatic start_run();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        start       = 1'b0;
        dec_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'd0;
        halt        = 1'b0;
        #2;
        n_checks++;
        if (imem_en !== 1'b0 || imem_addr !== 14'd0 || dec_valid !== 1'b0 ||
            pc !== 32'd0 || inst !== 32'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: got en=%b addr=%h dv=%b pc=%h inst=%h halted=%b, exp all zero",
                     imem_en, imem_addr, dec_valid, pc, inst, halted);
        end
        next_cycle();
        rstn = 1'b1;
        #2;
        n_checks++;
        if (imem_en !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: got en=%b dv=%b exp 0 0", imem_en, dec_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        do_reset();
        dec_ready = 1'b1;
        start = 1'b1;
        #2;
        n_checks++;
        if (imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_idle_en: got %b exp 0", imem_en);
        end
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #2;
            n_checks++;
            if (imem_en !== 1'b1 || imem_addr !== 14'(c - 1)) begin
                n_fail++;
                $display("FAIL stream_req c%0d: got en=%b addr=%h exp en=1 addr=%h",
                         c, imem_en, imem_addr, c - 1);
            end
            n_checks++;
            if (dec_valid !== (c >= 3)) begin
                n_fail++;
                $display("FAIL stream_dv c%0d: got %b exp %b", c, dec_valid, c >= 3);
            end
            if (c >= 3) begin
                ep = 32'((c - 3) * 4);
                n_checks++;
                if (pc !== ep || inst !== 32'(c - 3)) begin
                    n_fail++;
                    $display("FAIL stream_data c%0d: got pc=%h inst=%h exp pc=%h inst=%h",
                             c, pc, inst, ep, c - 3);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic        rdy    [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        exp_en [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [13:0] exp_ad [8] = '{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd2, 14'd3, 14'd4};
        logic [31:0] exp_pc [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd8};
        do_reset();
        dec_ready = 1'b1;
        start_run();
        next_cycle();
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            dec_ready = rdy[i];
            #2;
            n_checks++;
            if (imem_en !== exp_en[i] || (exp_en[i] && imem_addr !== exp_ad[i])) begin
                n_fail++;
                $display("FAIL stall_req c%0d: got en=%b addr=%h exp en=%b addr=%h",
                         i + 3, imem_en, imem_addr, exp_en[i], exp_ad[i]);
            end
            n_checks++;
            if (dec_valid !== 1'b1 || pc !== exp_pc[i] || inst !== (exp_pc[i] >> 2)) begin
                n_fail++;
                $display("FAIL stall_head c%0d: got dv=%b pc=%h inst=%h exp dv=1 pc=%h inst=%h",
                         i + 3, dec_valid, pc, inst, exp_pc[i], exp_pc[i] >> 2);
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect();
        logic        exp_dv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_pc [4] = '{32'h0, 32'h0, 32'h100, 32'h104};
        do_reset();
        dec_ready = 1'b1;
        start_run();
        next_cycle();
        next_cycle();
        redir_valid = 1'b1;
        redir_pc    = 32'h100;
        #2;
        n_checks++;
        if (imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle_en: got %b exp 0", imem_en);
        end
        next_cycle();
        redir_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++;
            if (imem_en !== 1'b1 || imem_addr !== 14'(32'h40 + i)) begin
                n_fail++;
                $display("FAIL redir_req +%0d: got en=%b addr=%h exp en=1 addr=%h",
                         i + 1, imem_en, imem_addr, 32'h40 + i);
            end
            n_checks++;
            if (dec_valid !== exp_dv[i] ||
                (exp_dv[i] && (pc !== exp_pc[i] || inst !== (exp_pc[i] >> 2)))) begin
                n_fail++;
                $display("FAIL redir_head +%0d: got dv=%b pc=%h inst=%h exp dv=%b pc=%h inst=%h",
                         i + 1, dec_valid, pc, inst, exp_dv[i], exp_pc[i], exp_pc[i] >> 2);
            end
            next_cycle();
        end
    endtask

    task automatic test_halt_redir();
        logic        exp_dv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_pc [4] = '{32'h0, 32'h0, 32'h20, 32'h24};
        do_reset();
        dec_ready = 1'b1;
        start_run();
        next_cycle();
        next_cycle();
        next_cycle();
        halt        = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h20;
        #2;
        n_checks++;
        if (imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL hr_cycle_en: got %b exp 0", imem_en);
        end
        next_cycle();
        halt        = 1'b0;
        redir_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++;
            if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 14'(8 + i)) begin
                n_fail++;
                $display("FAIL hr_req +%0d: got halted=%b en=%b addr=%h exp halted=0 en=1 addr=%h",
                         i + 1, halted, imem_en, imem_addr, 8 + i);
            end
            n_checks++;
            if (dec_valid !== exp_dv[i] || (exp_dv[i] && pc !== exp_pc[i])) begin
                n_fail++;
                $display("FAIL hr_head +%0d: got dv=%b pc=%h exp dv=%b pc=%h",
                         i + 1, dec_valid, pc, exp_dv[i], exp_pc[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_halt();
        do_reset();
        dec_ready = 1'b1;
        start_run();
        next_cycle();
        next_cycle();
        next_cycle();
        halt = 1'b1;
        next_cycle();
        halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                redir_valid = 1'b1;
                redir_pc    = 32'h200;
                start       = 1'b1;
            end
            #2;
            n_checks++;
            if (halted !== 1'b1 || imem_en !== 1'b0 || dec_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold +%0d: got halted=%b en=%b dv=%b exp 1 0 0",
                         i + 1, halted, imem_en, dec_valid);
            end
            next_cycle();
        end
        redir_valid = 1'b0;
        start       = 1'b0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        dec_ready = 1'b1;
        start_run();
        for (int i = 0; i < 4; i++) next_cycle();
        #1;
        n_checks++;
        if (dec_valid !== 1'b1 || pc !== 32'h8 || imem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got dv=%b pc=%h en=%b exp dv=1 pc=00000008 en=1",
                     dec_valid, pc, imem_en);
        end
        next_cycle();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (imem_en !== 1'b0 || imem_addr !== 14'd0 || dec_valid !== 1'b0 ||
            pc !== 32'd0 || inst !== 32'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_vals: got en=%b addr=%h dv=%b pc=%h inst=%h halted=%b, exp all zero",
                     imem_en, imem_addr, dec_valid, pc, inst, halted);
        end
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        start_run();
        for (int c = 1; c <= 3; c++) begin
            #2;
            n_checks++;
            if (dec_valid !== (c == 3) || (c == 3 && (pc !== 32'd0 || inst !== 32'd0))) begin
                n_fail++;
                $display("FAIL mid_restart c%0d: got dv=%b pc=%h inst=%h exp dv=%b pc=0 inst=0",
                         c, dec_valid, pc, inst, c == 3);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt_redir();
        test_halt();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
